// File: rtl/des_round_ctrl.sv
// Iterative DES sequencer: accepts a block, steps a shared round datapath NUM_ROUNDS times,
// strobes the final permutation and holds the result until the consumer takes it.
module des_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 16,
   parameter int unsigned CNT_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             decrypt,
   input  logic             abort,
   output logic             ld_data,
   output logic             rnd_en,
   output logic [CNT_W-1:0] round_idx,
   output logic [1:0]       shift_amt,
   output logic             shift_right,
   output logic             fp_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             mode_q
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_d;

   // Key-schedule rotate amount. Decrypt rotates right, and its first round
   // needs no rotation because C16/D16 equal C0/D0.
   function automatic logic [1:0] shift_of(input logic [CNT_W-1:0] r, input logic dec);
      logic single;
      single = (r == CNT_W'(2)) || (r == CNT_W'(9)) || (r == CNT_W'(16));
      if (r == CNT_W'(1))
         shift_of = dec ? 2'd0 : 2'd1;
      else if (single)
         shift_of = 2'd1;
      else
         shift_of = 2'd2;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mode_d  = decrypt;
               cnt_d   = CNT_W'(1);
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST_RND) begin
               state_d = S_FINAL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FINAL: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            // abort takes priority, but both paths discard the block the same way
            if (abort || out_ready) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign busy        = ~in_ready;
   assign ld_data     = in_ready & in_valid;
   assign rnd_en      = (state_q == S_ROUND);
   assign round_idx   = rnd_en ? cnt_q : '0;
   assign shift_amt   = rnd_en ? shift_of(cnt_q, mode_q) : 2'd0;
   assign shift_right = rnd_en & mode_q;
   assign fp_en       = (state_q == S_FINAL);
   assign out_valid   = (state_q == S_DONE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: directed scenarios then random traffic, every cycle compared
// against a cycle-age reference model of the block lifecycle.
module tb_des_round_ctrl;

   logic       clk = 1'b0;
   logic       rst, in_valid, decrypt, abort, out_ready;
   logic       in_ready, ld_data, rnd_en, shift_right, fp_en, out_valid, busy, mode_q;
   logic [4:0] round_idx;
   logic [1:0] shift_amt;

   int n_tests = 0;
   int n_fail  = 0;

   // model: age = cycles since accept (0 = idle, saturates at 18 = holding output)
   int age  = 0;
   bit mode = 1'b0;
   int enc_tbl [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   int dec_tbl [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   always #5 clk = ~clk;

   des_round_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .decrypt(decrypt),
      .abort(abort), .ld_data(ld_data), .rnd_en(rnd_en), .round_idx(round_idx),
      .shift_amt(shift_amt), .shift_right(shift_right), .fp_en(fp_en),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .mode_q(mode_q)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d (age %0d)", tag, $time, got, exp, age);
      end
   endtask

   // compare one cycle at the falling edge, then advance the model across the rising edge
   task automatic cyc();
      bit rnd;
      int e_sh;
      @(negedge clk);
      rnd  = (age >= 1 && age <= 16);
      e_sh = rnd ? (mode ? dec_tbl[age-1] : enc_tbl[age-1]) : 0;
      chk("in_ready",    int'(in_ready),    int'(age == 0));
      chk("busy",        int'(busy),        int'(age != 0));
      chk("ld_data",     int'(ld_data),     int'(age == 0 && in_valid));
      chk("rnd_en",      int'(rnd_en),      int'(rnd));
      chk("round_idx",   int'(round_idx),   rnd ? age : 0);
      chk("shift_amt",   int'(shift_amt),   e_sh);
      chk("shift_right", int'(shift_right), int'(rnd && mode));
      chk("fp_en",       int'(fp_en),       int'(age == 17));
      chk("out_valid",   int'(out_valid),   int'(age == 18));
      chk("mode_q",      int'(mode_q),      int'(mode));
      if (rst) begin
         age  = 0;
         mode = 1'b0;
      end else if (age == 0) begin
         if (in_valid) begin
            age  = 1;
            mode = decrypt;
         end
      end else if (abort) begin
         age = 0;
      end else if (age < 18) begin
         age++;
      end else if (out_ready) begin
         age = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; abort = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc();
      rst = 1'b0;
      run(3);

      // encrypt block
      in_valid = 1'b1; decrypt = 1'b0;
      cyc();
      in_valid = 1'b0;
      run(20);

      // decrypt block
      in_valid = 1'b1; decrypt = 1'b1;
      cyc();
      in_valid = 1'b0;
      run(20);

      // output backpressure with in_valid pushed while busy
      out_ready = 1'b0; in_valid = 1'b1; decrypt = 1'b0;
      cyc();
      in_valid = 1'b0;
      run(18);
      in_valid = 1'b1; decrypt = 1'b1;
      run(5);
      out_ready = 1'b1;
      run(2);
      in_valid = 1'b0;
      run(20);

      // abort at round 7, then a fresh block
      in_valid = 1'b1; decrypt = 1'b0;
      cyc();
      in_valid = 1'b0;
      run(6);
      abort = 1'b1; in_valid = 1'b1;
      cyc();
      abort = 1'b0;
      run(2);
      in_valid = 1'b0;
      run(20);

      // reset while holding output, with out_ready asserted in the same cycle
      out_ready = 1'b0; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      run(19);
      rst = 1'b1; out_ready = 1'b1; abort = 1'b1;
      cyc();
      rst = 1'b0; abort = 1'b0;
      run(3);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) == 0);
         decrypt   = 1'($urandom_range(0, 1));
         abort     = ($urandom_range(0, 63) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
      run(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
